// File: rtl/s3_trit_packer_pkg.sv
// Shared definitions for the S3 trit packer: trit codes, base-3 slot
// weights and the packed-length helper used to size absorb counts.
package s3_trit_packer_pkg;

  localparam int TRITS_PER_BYTE = 5;

  // Weight of each slot within a byte, slot 0 is least significant.
  localparam logic [7:0] TRIT_WEIGHTS [TRITS_PER_BYTE] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};

  typedef enum logic [1:0] {
    TRIT_ZERO    = 2'd0,
    TRIT_ONE     = 2'd1,
    TRIT_TWO     = 2'd2,
    TRIT_ILLEGAL = 2'd3
  } trit_t;

  // Number of packed bytes for a frame of n coefficients.
  function automatic int packed_len(input int n);
    return (n + TRITS_PER_BYTE - 1) / TRITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/s3_byte_accumulator.sv
// Base-3 accumulator: holds the slot counter and the partial byte, and
// adds trit*weight for every accepted trit. Signals completion when the
// fifth slot is filled or the caller forces an early finish at frame end.
module s3_byte_accumulator
  import s3_trit_packer_pkg::*;
(
  input  logic       clk,
  input  logic       ovr_rst_n,
  input  logic       accept,
  input  logic [1:0] trit_in,
  input  logic       force_last,
  output logic [7:0] acc_next,
  output logic       complete,
  output logic       illegal
);

  logic [2:0] slot;
  logic [7:0] acc;
  logic [7:0] weight;
  logic [7:0] term;
  trit_t      trit;

  // Weight select, trit scaling and completion detect; code 3 adds nothing.
  always_comb begin
    trit    = trit_t'(trit_in);
    weight  = 8'd0;
    term    = 8'd0;
    illegal = 1'b0;
    case (slot)
      3'd0:    weight = TRIT_WEIGHTS[0];
      3'd1:    weight = TRIT_WEIGHTS[1];
      3'd2:    weight = TRIT_WEIGHTS[2];
      3'd3:    weight = TRIT_WEIGHTS[3];
      3'd4:    weight = TRIT_WEIGHTS[4];
      default: weight = 8'd0;
    endcase
    case (trit)
      TRIT_ONE:     term = weight;
      TRIT_TWO:     term = {weight[6:0], 1'b0};
      TRIT_ILLEGAL: illegal = 1'b1;
      default:      term = 8'd0;
    endcase
    acc_next = acc + term;
    complete = accept & ((slot == 3'(TRITS_PER_BYTE - 1)) | force_last);
  end

  // Slot and partial-byte registers; both restart at zero after each byte.
  always_ff @(posedge clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      slot <= 3'd0;
      acc  <= 8'd0;
    end else if (complete) begin
      slot <= 3'd0;
      acc  <= 8'd0;
    end else if (accept) begin
      slot <= slot + 3'd1;
      acc  <= acc_next;
    end
  end

endmodule

// File: rtl/s3_trit_packer.sv
// Packs a stream of mod-3 coefficients into bytes, five trits per byte,
// for the Keccak absorb stage. Keeps the coefficient counter, the single
// output register with its handshake, and the error/done flags.
module s3_trit_packer
  import s3_trit_packer_pkg::*;
#(
  parameter int N  = 701,
  parameter int CW = 10
) (
  input  logic       clk,
  input  logic       ovr_rst_n,
  input  logic       trit_valid,
  input  logic [1:0] trit_in,
  output logic       trit_ready,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_last,
  input  logic       byte_ready,
  output logic       frame_done,
  output logic       trit_err
);

  localparam logic [CW-1:0] LAST_COEF = CW'(N - 1);

  logic [CW-1:0] coef;
  logic          accept;
  logic          last_coef;
  logic          first_coef;
  logic [7:0]    acc_next;
  logic          acc_complete;
  logic          acc_illegal;

  // A trit may enter whenever the output slot is free or draining this cycle.
  assign trit_ready = ~byte_valid | byte_ready;
  assign accept     = trit_valid & trit_ready;
  assign last_coef  = (coef == LAST_COEF);
  assign first_coef = (coef == '0);

  s3_byte_accumulator u_acc (
    .clk        (clk),
    .ovr_rst_n  (ovr_rst_n),
    .accept     (accept),
    .trit_in    (trit_in),
    .force_last (last_coef),
    .acc_next   (acc_next),
    .complete   (acc_complete),
    .illegal    (acc_illegal)
  );

  // Coefficient position within the frame, wrapping after the last one.
  always_ff @(posedge clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      coef <= '0;
    end else if (accept) begin
      coef <= last_coef ? '0 : coef + 1'b1;
    end
  end

  // Output register: a completing trit reloads it even while it drains.
  always_ff @(posedge clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      byte_valid <= 1'b0;
      byte_out   <= 8'd0;
      byte_last  <= 1'b0;
    end else if (acc_complete) begin
      byte_valid <= 1'b1;
      byte_out   <= acc_next;
      byte_last  <= last_coef;
    end else if (byte_valid && byte_ready) begin
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
    end
  end

  // One-cycle pulse following the hand-off of a frame's final byte.
  always_ff @(posedge clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= byte_valid & byte_ready & byte_last;
    end
  end

  // Sticky illegal-code flag, restarted by the first trit of each frame.
  always_ff @(posedge clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      trit_err <= 1'b0;
    end else if (accept) begin
      if (first_coef) begin
        trit_err <= acc_illegal;
      end else if (acc_illegal) begin
        trit_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/s3_trit_packer.md
Name: s3_trit_packer

Overview:
- Upstream feeder for the hash stage of the encapsulation datapath.
- Takes a stream of mod-3 coefficients (trits) from the ternary-add unit and packs each group of 5 trits into one byte, base 3, as in the HRSS pack_S3 format.
- Emits a byte stream for the Keccak absorb logic.
- One polynomial of N coefficients gives ceil(N/5) bytes. The last byte is zero-padded and flagged.

Parameters:
- N, 701, number of coefficients per polynomial frame; N >= 1.
- CW, 10, width of the coefficient counter; must satisfy 2^CW > N.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- ovr_rst_n  in  1  asynchronous, active-low reset.
- trit_valid  in  1  input trit present.
- trit_in  in  2  trit value: 0, 1 or 2; code 3 is illegal.
- trit_ready  out  1  packer accepts trit this cycle.
- byte_valid  out  1  packed byte present.
- byte_out  out  8  packed byte, value 0..242.
- byte_last  out  1  qualifies byte_valid: final byte of the frame.
- byte_ready  in  1  hash stage accepts the byte.
- frame_done  out  1  one-cycle pulse when the last byte of a frame is accepted.
- trit_err  out  1  sticky: an illegal trit code was seen in the current frame.

Behaviour:
- Reset (asynchronous, ovr_rst_n low) clears everything, regardless of clk:
  - Outputs: byte_valid=0, byte_out=0, byte_last=0, frame_done=0, trit_err=0.
  - Internal state: slot=0, coef=0, acc=0.
  - An in-flight partial byte or held output byte is discarded, with no byte_last.
  - After release, the first accepted trit is coefficient 0 of a new frame.
- Handshakes:
  - Input transfer when trit_valid & trit_ready.
  - Output transfer when byte_valid & byte_ready.
  - trit_ready = ~byte_valid | byte_ready, combinational from byte_ready. This allows full throughput of 1 trit/cycle with a 1-entry output register and no bubble.
- Data and weighting:
  - Weights by slot 0..4 are 1, 3, 9, 27, 81.
  - On each accepted trit, acc_next = acc + t*w[slot], computed at 8-bit width. The maximum is 242, so there is no overflow.
  - An illegal code 3 is treated as t=0 and sets trit_err.
- Byte completion: happens on an accepted trit when slot==4 or coef==N-1.
  - byte_out <= acc_next, byte_valid <= 1, byte_last <= (coef==N-1).
  - acc <= 0, slot <= 0.
  - Otherwise slot <= slot+1 and acc <= acc_next.
- Coefficient counter:
  - coef increments on every accepted trit and wraps to 0 after N-1.
  - Slot wraps independently at byte completion, so a partial last byte restarts the next frame at slot 0.
- Output register:
  - Latency: byte_valid rises the cycle after the completing trit is accepted.
  - byte_valid clears on transfer unless a new byte completes in the same cycle. In that case the register reloads, with no gap.
  - byte_out and byte_last hold stable while byte_valid & ~byte_ready.
- frame_done is registered: high exactly one cycle after a transfer with byte_last=1.
- trit_err:
  - Set on an illegal trit.
  - Cleared when coefficient 0 of the next frame is accepted.
  - If that first trit is itself illegal, set wins.
- Back-pressure: trits are never dropped or duplicated. Holding trit_valid while trit_ready is low is legal, and trit_in must stay stable.
- States:
  - IDLE: coef=0, slot=0, no output pending.
  - ACC: partial byte held.
  - HOLD: byte_valid & ~byte_ready; input stalls.
  - ACC and HOLD can coexist: a partial byte accumulates while a full byte waits. This is legal only while the next trit does not complete a byte. With 1-entry output, trit_ready low in HOLD enforces this.
- N=1 edge: every trit is both coefficient 0 and the last, giving one byte per frame with byte_last=1.

Decomposition:
- Shared package holds:
  - TRITS_PER_BYTE=5.
  - Localparam array of the base-3 weights {1,3,9,27,81}.
  - Trit typedef (2-bit, codes ZERO/ONE/TWO/ILLEGAL).
  - Function packed_len(N)=ceil(N/5), also used by the hash control to size its absorb count.
- One sub-module is natural: s3_byte_accumulator, holding the slot counter, acc register, weight mux and adder. The top keeps the coef counter, output register, handshake logic and error/done flags.

Test Plan:
- Trits 2,1,0,2,1 at coef 0..4, byte_ready=1 -> byte_out=0x8C (140) one cycle after the 5th trit; byte_last=0.
- N=701, all trits 1, byte_ready=1 -> 140 bytes of 0x79 (121), then 1 byte of 0x01 with byte_last=1; frame_done pulses once; 701 trits accepted in 701 cycles.
- N=7, all trits 2, byte_ready toggling 1/0 each cycle -> bytes 0xF2 then 0x08 (2+6) with last=1. byte_out stays stable while stalled. trit_ready is low only while byte_valid & ~byte_ready.
- Frame with trit code 3 at coef 2 (others 1) -> that slot counts as 0, so byte = 1+3+27+81 = 112 (0x70); trit_err=1 until coef 0 of the next frame.
- Assert ovr_rst_n=0 mid-byte (slot 3) and again while HOLD -> all outputs 0 immediately; after release, trits 1,1,1,1,1 give 0x79 with no residue from the prior state.
- Back-to-back frames, N=7, continuous valid/ready -> byte_last on every 2nd byte, 7 trits/frame, no idle cycles between frames.
